// File: rtl/srec_pkg.sv
// Shared types and helpers for the Motorola S-record loader.
package srec_pkg;

  typedef enum logic [2:0] {IDLE, TYPE, COUNT, ADDR, DATA, CSUM} state_t;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [2:0] addr_bytes(input logic [3:0] rec_type);
    case (rec_type)
      4'd2, 4'd6, 4'd8: return 3'd3;
      4'd3, 4'd7:       return 3'd4;
      default:          return 3'd2;
    endcase
  endfunction

  function automatic logic writes_mem(input logic [3:0] rec_type);
    return (rec_type == 4'd1) || (rec_type == 4'd2) || (rec_type == 4'd3);
  endfunction

  function automatic logic is_entry(input logic [3:0] rec_type);
    return (rec_type == 4'd7) || (rec_type == 4'd8) || (rec_type == 4'd9);
  endfunction

endpackage

// File: rtl/hex_ascii_decoder.sv
// Combinational ASCII hex digit decoder (0-9, A-F, a-f).
module hex_ascii_decoder (
  input  logic [7:0] ascii,
  output logic [3:0] nibble,
  output logic       hex_ok
);

  always_comb begin
    nibble = 4'd0;
    hex_ok = 1'b0;
    if (ascii >= 8'h30 && ascii <= 8'h39) begin
      nibble = ascii[3:0];
      hex_ok = 1'b1;
    end else if ((ascii >= 8'h41 && ascii <= 8'h46) || (ascii >= 8'h61 && ascii <= 8'h66)) begin
      nibble = ascii[3:0] + 4'd9;
      hex_ok = 1'b1;
    end
  end

endmodule

// File: rtl/srec_loader.sv
// S-record byte-stream parser: issues memory writes, checks checksums, captures entry address.
module srec_loader
  import srec_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_byte,
  output logic                   wr_valid,
  output logic [ADDR_WIDTH-1:0]  wr_addr,
  output logic [7:0]             wr_data,
  output logic                   rec_done,
  output logic                   err_checksum,
  output logic                   err_format,
  output logic                   entry_valid,
  output logic [ADDR_WIDTH-1:0]  entry_addr,
  output logic [COUNT_WIDTH-1:0] record_count
);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  state_t                  state;
  logic                    have_hi;
  logic [3:0]              hi_nib;
  logic [3:0]              rec_type;
  logic [7:0]              sum;
  logic [2:0]              addr_left;
  logic [7:0]              data_left;
  logic [31:0]             addr_sh;
  logic [ADDR_WIDTH-1:0]   cur_addr;

  logic [3:0]  nib;
  logic        hex_ok;
  logic [7:0]  byte_val;
  logic [7:0]  hdr_bytes;
  logic [7:0]  sum_final;
  logic [31:0] addr_next;
  logic        type_ok;

  hex_ascii_decoder u_hex (
    .ascii  (rx_byte),
    .nibble (nib),
    .hex_ok (hex_ok)
  );

  assign byte_val  = {hi_nib, nib};
  assign hdr_bytes = {5'd0, addr_bytes(rec_type)} + 8'd1;
  assign sum_final = sum + byte_val;
  assign addr_next = {addr_sh[23:0], byte_val};
  assign type_ok   = (rx_byte >= 8'h30) && (rx_byte <= 8'h39) && (rx_byte != 8'h34);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      have_hi      <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      rec_done     <= 1'b0;
      err_checksum <= 1'b0;
      err_format   <= 1'b0;
      entry_valid  <= 1'b0;
      entry_addr   <= '0;
      record_count <= '0;
    end else begin
      wr_valid     <= 1'b0;
      rec_done     <= 1'b0;
      err_checksum <= 1'b0;
      err_format   <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE: if (rx_byte == ASCII_S) state <= TYPE;
          TYPE: begin
            have_hi <= 1'b0;
            if (type_ok) begin
              rec_type <= rx_byte[3:0];
              state    <= COUNT;
            end else begin
              err_format <= 1'b1;
              state      <= IDLE;
            end
          end
          default: begin
            // A stray 'S' inside a record is taken as the start of the next one.
            if (!hex_ok) begin
              err_format <= 1'b1;
              have_hi    <= 1'b0;
              state      <= (rx_byte == ASCII_S) ? TYPE : IDLE;
            end else if (!have_hi) begin
              hi_nib  <= nib;
              have_hi <= 1'b1;
            end else begin
              have_hi <= 1'b0;
              case (state)
                COUNT: begin
                  if (byte_val < hdr_bytes) begin
                    err_format <= 1'b1;
                    state      <= IDLE;
                  end else begin
                    sum       <= byte_val;
                    addr_left <= addr_bytes(rec_type);
                    addr_sh   <= '0;
                    data_left <= byte_val - hdr_bytes;
                    state     <= ADDR;
                  end
                end
                ADDR: begin
                  sum       <= sum_final;
                  addr_sh   <= addr_next;
                  addr_left <= addr_left - 3'd1;
                  if (addr_left == 3'd1) begin
                    cur_addr <= ADDR_WIDTH'(addr_next);
                    state    <= (data_left != 8'd0) ? DATA : CSUM;
                  end
                end
                DATA: begin
                  sum <= sum_final;
                  if (writes_mem(rec_type)) begin
                    wr_valid <= 1'b1;
                    wr_addr  <= cur_addr;
                    wr_data  <= byte_val;
                  end
                  cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                  data_left <= data_left - 8'd1;
                  if (data_left == 8'd1) state <= CSUM;
                end
                CSUM: begin
                  state <= IDLE;
                  if (sum_final == 8'hFF) begin
                    rec_done     <= 1'b1;
                    record_count <= sat_inc(record_count);
                    if (is_entry(rec_type)) begin
                      entry_valid <= 1'b1;
                      entry_addr  <= ADDR_WIDTH'(addr_sh);
                    end
                  end else begin
                    err_checksum <= 1'b1;
                  end
                end
                default: state <= IDLE;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_srec_loader.sv
// Directed bench for srec_loader (16-bit addresses, 3-bit saturating record counter).
module tb_srec_loader;
  import srec_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        rec_done, err_checksum, err_format, entry_valid;
  logic [15:0] entry_addr;
  logic [2:0]  record_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  int n_done = 0, n_cks = 0, n_fmt = 0, n_multi = 0;
  logic [15:0] wq_addr[$];
  logic [7:0]  wq_data[$];

  srec_loader #(.ADDR_WIDTH(16), .COUNT_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rec_done(rec_done), .err_checksum(err_checksum), .err_format(err_format),
    .entry_valid(entry_valid), .entry_addr(entry_addr), .record_count(record_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset) begin
      if (wr_valid) begin
        wq_addr.push_back(wr_addr);
        wq_data.push_back(wr_data);
      end
      if (rec_done) n_done++;
      if (err_checksum) n_cks++;
      if (err_format) n_fmt++;
      if (int'(rec_done) + int'(err_checksum) + int'(err_format) > 1) n_multi++;
    end
  end

  task automatic clear_mon();
    wq_addr.delete();
    wq_data.delete();
    n_done = 0; n_cks = 0; n_fmt = 0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clock);
      rx_valid = 1'b1;
      rx_byte  = s[i];
    end
    @(negedge clock);
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic bump_cnt();
    exp_cnt = (exp_cnt < 7) ? exp_cnt + 1 : 7;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    checks++;
    if (wr_valid !== 1'b0 || rec_done !== 1'b0 || err_checksum !== 1'b0 || err_format !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: got wr=%b done=%b cks=%b fmt=%b expected all 0", wr_valid, rec_done, err_checksum, err_format);
    end
    checks++;
    if (wr_addr !== 16'h0 || wr_data !== 8'h0 || entry_valid !== 1'b0 || entry_addr !== 16'h0 || record_count !== 3'd0) begin
      errors++; $display("FAIL reset_values: got addr=%h data=%h ev=%b ea=%h cnt=%0d expected all 0", wr_addr, wr_data, entry_valid, entry_addr, record_count);
    end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good_record();
    clear_mon();
    send_str("S1050010AABB8");
    rx_valid = 1'b1;
    rx_byte  = "5";
    @(negedge clock);
    rx_valid = 1'b0;
    checks++;
    if (rec_done !== 1'b1) begin
      errors++; $display("FAIL good_done_latency: got %b expected 1", rec_done);
    end
    @(negedge clock);
    checks++;
    if (rec_done !== 1'b0) begin
      errors++; $display("FAIL good_done_width: got %b expected 0", rec_done);
    end
    send_str({8'(ASCII_CR), 8'(ASCII_LF)});
    idle(3);
    bump_cnt();
    checks++;
    if (wq_addr.size() != 2) begin
      errors++; $display("FAIL good_wr_count: got %0d expected 2", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 16'h0010 || wq_data[0] !== 8'hAA || wq_addr[1] !== 16'h0011 || wq_data[1] !== 8'hBB) begin
        errors++; $display("FAIL good_wr_values: got %h/%h %h/%h expected 0010/aa 0011/bb", wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
      end
    end
    checks++;
    if (n_done != 1 || n_cks != 0 || n_fmt != 0 || record_count !== exp_cnt[2:0]) begin
      errors++; $display("FAIL good_status: got done=%0d cks=%0d fmt=%0d cnt=%0d expected 1 0 0 %0d", n_done, n_cks, n_fmt, record_count, exp_cnt);
    end
  endtask

  task automatic test_bad_checksum();
    clear_mon();
    send_str("S1050010AABB86");
    idle(3);
    checks++;
    if (wq_addr.size() != 2) begin
      errors++; $display("FAIL badcks_wr_count: got %0d expected 2", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 16'h0010 || wq_data[0] !== 8'hAA || wq_addr[1] !== 16'h0011 || wq_data[1] !== 8'hBB) begin
        errors++; $display("FAIL badcks_wr_values: got %h/%h %h/%h expected 0010/aa 0011/bb", wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
      end
    end
    checks++;
    if (n_cks != 1 || n_done != 0 || n_fmt != 0 || record_count !== exp_cnt[2:0]) begin
      errors++; $display("FAIL badcks_status: got cks=%0d done=%0d fmt=%0d cnt=%0d expected 1 0 0 %0d", n_cks, n_done, n_fmt, record_count, exp_cnt);
    end
  endtask

  task automatic test_s3_truncate();
    clear_mon();
    send_str("S306123456789A4B");
    idle(3);
    bump_cnt();
    checks++;
    if (wq_addr.size() != 1) begin
      errors++; $display("FAIL s3_wr_count: got %0d expected 1", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 16'h5678 || wq_data[0] !== 8'h9A) begin
        errors++; $display("FAIL s3_wr_value: got %h/%h expected 5678/9a", wq_addr[0], wq_data[0]);
      end
    end
    checks++;
    if (n_done != 1 || n_cks != 0 || n_fmt != 0 || record_count !== exp_cnt[2:0]) begin
      errors++; $display("FAIL s3_status: got done=%0d cks=%0d fmt=%0d cnt=%0d expected 1 0 0 %0d", n_done, n_cks, n_fmt, record_count, exp_cnt);
    end
  endtask

  task automatic test_entry();
    clear_mon();
    send_str("S9030100FB");
    idle(3);
    bump_cnt();
    checks++;
    if (wq_addr.size() != 0 || entry_valid !== 1'b1 || entry_addr !== 16'h0100) begin
      errors++; $display("FAIL entry_s9: got writes=%0d ev=%b ea=%h expected 0 1 0100", wq_addr.size(), entry_valid, entry_addr);
    end
    checks++;
    if (n_done != 1 || record_count !== exp_cnt[2:0]) begin
      errors++; $display("FAIL entry_status: got done=%0d cnt=%0d expected 1 %0d", n_done, record_count, exp_cnt);
    end
  endtask

  task automatic test_format();
    clear_mon();
    send_str("S1G5");
    send_str("S4");
    send_str("S10S1050010AABB85");
    idle(3);
    bump_cnt();
    checks++;
    if (n_fmt != 3 || n_done != 1 || n_cks != 0) begin
      errors++; $display("FAIL format_pulses: got fmt=%0d done=%0d cks=%0d expected 3 1 0", n_fmt, n_done, n_cks);
    end
    checks++;
    if (wq_addr.size() != 2) begin
      errors++; $display("FAIL format_wr_count: got %0d expected 2", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 16'h0010 || wq_data[0] !== 8'hAA || wq_addr[1] !== 16'h0011 || wq_data[1] !== 8'hBB) begin
        errors++; $display("FAIL format_wr_values: got %h/%h %h/%h expected 0010/aa 0011/bb", wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
      end
    end
    clear_mon();
    send_str("S1020000\r\n");
    idle(3);
    checks++;
    if (n_fmt != 1 || n_done != 0 || wq_addr.size() != 0) begin
      errors++; $display("FAIL format_short_count: got fmt=%0d done=%0d writes=%0d expected 1 0 0", n_fmt, n_done, wq_addr.size());
    end
  endtask

  task automatic test_variants();
    clear_mon();
    send_str("S1050010aabb85");
    send_str("S0050000AABB95");
    idle(3);
    bump_cnt();
    bump_cnt();
    checks++;
    if (wq_addr.size() != 2 || n_done != 2 || n_fmt != 0 || n_cks != 0 || record_count !== exp_cnt[2:0]) begin
      errors++; $display("FAIL lower_and_s0: got writes=%0d done=%0d fmt=%0d cks=%0d cnt=%0d expected 2 2 0 0 %0d", wq_addr.size(), n_done, n_fmt, n_cks, record_count, exp_cnt);
    end
    clear_mon();
    send_str("S105FFFF1122C9");
    idle(3);
    bump_cnt();
    checks++;
    if (wq_addr.size() != 2) begin
      errors++; $display("FAIL wrap_wr_count: got %0d expected 2", wq_addr.size());
    end else begin
      checks++;
      if (wq_addr[0] !== 16'hFFFF || wq_data[0] !== 8'h11 || wq_addr[1] !== 16'h0000 || wq_data[1] !== 8'h22) begin
        errors++; $display("FAIL wrap_wr_values: got %h/%h %h/%h expected ffff/11 0000/22", wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
      end
    end
    clear_mon();
    send_str("S9031234B6");
    idle(3);
    bump_cnt();
    checks++;
    if (n_done != 1 || record_count !== 3'd7 || record_count !== exp_cnt[2:0] || entry_addr !== 16'h1234) begin
      errors++; $display("FAIL saturate_s9: got done=%0d cnt=%0d ea=%h expected 1 7 1234", n_done, record_count, entry_addr);
    end
    clear_mon();
    send_str("S8041234565F");
    idle(3);
    checks++;
    if (n_done != 1 || entry_addr !== 16'h3456 || entry_valid !== 1'b1 || record_count !== 3'd7) begin
      errors++; $display("FAIL s8_entry: got done=%0d ea=%h ev=%b cnt=%0d expected 1 3456 1 7", n_done, entry_addr, entry_valid, record_count);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    send_str("S1050010A");
    reset = 1'b1;
    idle(2);
    checks++;
    if (wr_valid !== 1'b0 || entry_valid !== 1'b0 || entry_addr !== 16'h0 || record_count !== 3'd0 || wr_addr !== 16'h0 || wr_data !== 8'h0) begin
      errors++; $display("FAIL midreset_outputs: got wr=%b ev=%b ea=%h cnt=%0d addr=%h data=%h expected all 0", wr_valid, entry_valid, entry_addr, record_count, wr_addr, wr_data);
    end
    reset = 1'b0;
    exp_cnt = 0;
    idle(1);
    send_str("ABB85\r\n");
    idle(3);
    checks++;
    if (wq_addr.size() != 0 || n_done != 0 || n_fmt != 0 || n_cks != 0) begin
      errors++; $display("FAIL midreset_discard: got writes=%0d done=%0d fmt=%0d cks=%0d expected 0 0 0 0", wq_addr.size(), n_done, n_fmt, n_cks);
    end
    send_str("S1050010AABB85");
    idle(3);
    bump_cnt();
    checks++;
    if (wq_addr.size() != 2 || n_done != 1 || record_count !== exp_cnt[2:0]) begin
      errors++; $display("FAIL midreset_good: got writes=%0d done=%0d cnt=%0d expected 2 1 %0d", wq_addr.size(), n_done, record_count, exp_cnt);
    end else begin
      checks++;
      if (wq_addr[0] !== 16'h0010 || wq_data[0] !== 8'hAA || wq_addr[1] !== 16'h0011 || wq_data[1] !== 8'hBB) begin
        errors++; $display("FAIL midreset_wr_values: got %h/%h %h/%h expected 0010/aa 0011/bb", wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (n_multi != 0) begin
      errors++; $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", n_multi);
    end
  endtask

  initial begin
    test_reset();
    test_good_record();
    test_bad_checksum();
    test_s3_truncate();
    test_entry();
    test_format();
    test_variants();
    test_reset_mid();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
